// File: rtl/tx_write_arbiter.sv
// -----------------------------------------------------------------------------
// tx_write_arbiter
//
// Round-robin arbiter that lets NUM_REQ byte-stream requesters take turns
// writing bursts into a single transmitter FIFO. A grant costs one idle cycle.
// After that the owner streams bytes with no gaps until one of these happens:
// it marks the last byte, it reaches MAX_BURST bytes, or it drops its request.
// While the FIFO is full or a configuration access is in progress, the burst
// stalls and keeps its lock.
//
// Ports
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   req_i            per-requester byte valid
//   data_i           per-requester byte, requester k on bits [8k+7:8k]
//   last_i           per-requester end-of-burst marker (qualified by req_i)
//   ack_o            one-hot byte-accepted strobe
//   tx_fifo_full_i   transmitter FIFO full
//   config_busy_i    configuration in progress, blocks all writes
//   data_tx_o        byte to transmitter FIFO
//   tx_fifo_write_o  transmitter FIFO write strobe
//   owner_o          current / last granted requester
//   busy_o           high while a requester holds the lock
// -----------------------------------------------------------------------------
module tx_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*8-1:0]       data_i,
   input  logic [NUM_REQ-1:0]         last_i,
   output logic [NUM_REQ-1:0]         ack_o,
   input  logic                       tx_fifo_full_i,
   input  logic                       config_busy_i,
   output logic [7:0]                 data_tx_o,
   output logic                       tx_fifo_write_o,
   output logic [$clog2(NUM_REQ)-1:0] owner_o,
   output logic                       busy_o
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state_reg;
   logic [OW-1:0] owner_reg;
   logic [OW-1:0] last_owner_reg;
   logic [CW-1:0] beat_reg;

   logic [7:0]    byte_lane [NUM_REQ];
   logic [OW-1:0] pick;
   logic          pick_valid;
   logic          accept;
   logic          release_lock;

   // Split the flat data bus into one byte per requester.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign byte_lane[gi] = data_i[8*gi +: 8];
         assign ack_o[gi]     = accept && (owner_reg == OW'(gi));
      end
   endgenerate

   // Rotating priority: the search starts just after the previous owner, so
   // a port that keeps requesting waits through at most NUM_REQ-1 other grants.
   always_comb begin
      int idx;
      idx        = 0;
      pick       = '0;
      pick_valid = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_owner_reg) + i) % NUM_REQ;
         if (!pick_valid && req_i[OW'(idx)]) begin
            pick       = OW'(idx);
            pick_valid = 1'b1;
         end
      end
   end

   // The byte is accepted in the same cycle it is presented.
   assign accept = (state_reg == LOCKED) && req_i[owner_reg]
                   && !tx_fifo_full_i && !config_busy_i;

   // A dropped request ends the burst even during a stall. The other two
   // release reasons need the current byte to be accepted.
   assign release_lock = (state_reg == LOCKED) &&
                         (!req_i[owner_reg] ||
                          (accept && (last_i[owner_reg] ||
                                      beat_reg == CW'(MAX_BURST - 1))));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg      <= IDLE;
         owner_reg      <= '0;
         last_owner_reg <= OW'(NUM_REQ - 1);
         beat_reg       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!config_busy_i && pick_valid) begin
                  owner_reg <= pick;
                  beat_reg  <= '0;
                  state_reg <= LOCKED;
               end
            end
            LOCKED: begin
               if (release_lock) begin
                  last_owner_reg <= owner_reg;
                  state_reg      <= IDLE;
               end else if (accept) begin
                  beat_reg <= beat_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign tx_fifo_write_o = accept;
   assign data_tx_o       = byte_lane[owner_reg];
   assign owner_o         = owner_reg;
   assign busy_o          = (state_reg == LOCKED);

endmodule
